// File: rtl/wb_lockstep_checker_if.sv
// Commit-stream bundle carrying one writeback port from each core into the checker.
// Latency: none, wires only.
// Backpressure: none; the cores commit freely and the checker buffers or flags overflow.
interface wb_lockstep_checker_if #(
    parameter int REG_BITS  = 5,
    parameter int DATA_SIZE = 32
);
    logic                 dut_we;
    logic [REG_BITS-1:0]  dut_reg;
    logic [DATA_SIZE-1:0] dut_data;
    logic                 gold_we;
    logic [REG_BITS-1:0]  gold_reg;
    logic [DATA_SIZE-1:0] gold_data;

    // The side that produces commits (core wrappers or a testbench).
    modport master (
        output dut_we, dut_reg, dut_data,
        output gold_we, gold_reg, gold_data
    );

    // The checker side that consumes commits.
    modport slave (
        input dut_we, dut_reg, dut_data,
        input gold_we, gold_reg, gold_data
    );
endinterface

// File: rtl/wb_lockstep_checker.sv
// Small synchronous FIFO holding one commit stream for the lockstep checker.
// Latency: an entry pushed at an edge is visible at head in the following cycle.
// Backpressure: none; the caller must not push when full unless it pops in the same cycle.
module wb_lockstep_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdat,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign head = mem[rptr];

    // Storage write; when full, a simultaneous pop means wptr == rptr and the
    // slot being overwritten is exactly the one being read out this cycle.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr] <= wdat;
        end
    end

    // Pointers wrap modulo DEPTH; the separate count tells full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push);
            rptr  <= rptr + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// Lockstep commit checker: buffers both writeback streams and compares heads in order.
// Latency: a commit pushed at edge k is compared at edge k+1 at the earliest; results visible after that edge.
// Backpressure: none toward the cores; a push into a full FIFO is dropped, flagged and halts the checker.
module wb_lockstep_checker #(
    parameter int DATA_SIZE     = 32,
    parameter int REG_BITS      = 5,
    parameter int DEPTH         = 8,
    parameter int TIMEOUT       = 64,
    parameter int CNT_BITS      = 16,
    parameter int STOP_ON_FIRST = 1,
    parameter int FILTER_X0     = 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    wb_lockstep_checker_if.slave          cif,
    output logic [CNT_BITS-1:0]           match_count,
    output logic [CNT_BITS-1:0]           mismatch_count,
    output logic                          first_valid,
    output logic [CNT_BITS-1:0]           first_index,
    output logic [REG_BITS+DATA_SIZE-1:0] first_dut,
    output logic [REG_BITS+DATA_SIZE-1:0] first_gold,
    output logic                          overflow,
    output logic                          timeout,
    output logic                          halted
);
    localparam int EW = REG_BITS + DATA_SIZE;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [REG_BITS-1:0]  rd;
        logic [DATA_SIZE-1:0] dat;
    } wb_ent_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    wb_ent_t       d_wdat;
    wb_ent_t       g_wdat;
    wb_ent_t       d_head;
    wb_ent_t       g_head;
    logic [CW-1:0] d_cnt;
    logic [CW-1:0] g_cnt;
    logic [CW-1:0] d_cnt_n;
    logic [CW-1:0] g_cnt_n;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;
    logic          run;
    logic          d_push_req;
    logic          g_push_req;
    logic          d_push;
    logic          g_push;
    logic          cmp;
    logic          is_match;
    logic          d_ovf;
    logic          g_ovf;
    logic          one_ne;
    logic          tout_hit;

    assign d_wdat = {cif.dut_reg, cif.dut_data};
    assign g_wdat = {cif.gold_reg, cif.gold_data};

    wb_lockstep_fifo #(.W(EW), .DEPTH(DEPTH)) u_dut_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (d_push),
        .pop   (cmp),
        .wdat  (d_wdat),
        .head  (d_head),
        .count (d_cnt)
    );

    wb_lockstep_fifo #(.W(EW), .DEPTH(DEPTH)) u_gold_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (g_push),
        .pop   (cmp),
        .wdat  (g_wdat),
        .head  (g_head),
        .count (g_cnt)
    );

    // Push/pop decisions, overflow and timeout detection, and the next state.
    always_comb begin
        state_n    = state;
        run        = (state == RUN);
        d_push_req = run && cif.dut_we  && !((FILTER_X0 != 0) && (cif.dut_reg  == '0));
        g_push_req = run && cif.gold_we && !((FILTER_X0 != 0) && (cif.gold_reg == '0));
        cmp        = run && (d_cnt != '0) && (g_cnt != '0);
        is_match   = (d_head == g_head);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        d_ovf      = d_push_req && (d_cnt == CW'(DEPTH)) && !cmp;
        g_ovf      = g_push_req && (g_cnt == CW'(DEPTH)) && !cmp;
        d_push     = d_push_req && !d_ovf;
        g_push     = g_push_req && !g_ovf;
        d_cnt_n    = d_cnt + CW'(d_push) - CW'(cmp);
        g_cnt_n    = g_cnt + CW'(g_push) - CW'(cmp);
        one_ne     = (d_cnt_n != '0) != (g_cnt_n != '0);
        tcnt_n     = (run && one_ne) ? (tcnt + TW'(1)) : '0;
        tout_hit   = run && one_ne && (tcnt_n == TW'(TIMEOUT));
        if (run && (d_ovf || g_ovf || tout_hit ||
                    (cmp && !is_match && (STOP_ON_FIRST != 0)))) begin
            state_n = HALT;
        end
    end

    // State register; only reset brings the checker back out of HALT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // Result counters, first-mismatch capture and sticky error flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            match_count    <= '0;
            mismatch_count <= '0;
            first_valid    <= 1'b0;
            first_index    <= '0;
            first_dut      <= '0;
            first_gold     <= '0;
            overflow       <= 1'b0;
            timeout        <= 1'b0;
            tcnt           <= '0;
        end else begin
            tcnt <= tcnt_n;
            if (cmp) begin
                if (is_match) begin
                    if (match_count != '1) match_count <= match_count + 1'b1;
                end else begin
                    if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
                    if (!first_valid) begin
                        first_valid <= 1'b1;
                        first_index <= match_count + mismatch_count;
                        first_dut   <= d_head;
                        first_gold  <= g_head;
                    end
                end
            end
            if (d_ovf || g_ovf) overflow <= 1'b1;
            if (tout_hit)       timeout  <= 1'b1;
        end
    end

    assign halted = (state == HALT);
endmodule

// File: tb/tb_wb_lockstep_checker.sv
module tb_wb_lockstep_checker;
    localparam int EW = 37;
    typedef logic [EW-1:0] ent_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    wb_lockstep_checker_if #(.REG_BITS(5), .DATA_SIZE(32)) bus ();

    logic [15:0] a_mc, a_mm, a_fi;
    logic [3:0]  b_mc, b_mm, b_fi;
    logic        a_fv, a_ovf, a_to, a_h, b_fv, b_ovf, b_to, b_h;
    ent_t        a_fd, a_fg, b_fd, b_fg;

    wb_lockstep_checker ua (
        .CLK(CLK), .RESET(RESET), .cif(bus),
        .match_count(a_mc), .mismatch_count(a_mm), .first_valid(a_fv),
        .first_index(a_fi), .first_dut(a_fd), .first_gold(a_fg),
        .overflow(a_ovf), .timeout(a_to), .halted(a_h)
    );

    wb_lockstep_checker #(.CNT_BITS(4), .STOP_ON_FIRST(0)) ub (
        .CLK(CLK), .RESET(RESET), .cif(bus),
        .match_count(b_mc), .mismatch_count(b_mm), .first_valid(b_fv),
        .first_index(b_fi), .first_dut(b_fd), .first_gold(b_fg),
        .overflow(b_ovf), .timeout(b_to), .halted(b_h)
    );

    logic [15:0] o_mc [2];
    logic [15:0] o_mm [2];
    logic [15:0] o_fi [2];
    logic        o_fv [2];
    logic        o_ov [2];
    logic        o_to [2];
    logic        o_h  [2];
    ent_t        o_fd [2];
    ent_t        o_fg [2];
    assign o_mc[0] = a_mc;  assign o_mc[1] = {12'd0, b_mc};
    assign o_mm[0] = a_mm;  assign o_mm[1] = {12'd0, b_mm};
    assign o_fi[0] = a_fi;  assign o_fi[1] = {12'd0, b_fi};
    assign o_fv[0] = a_fv;  assign o_fv[1] = b_fv;
    assign o_ov[0] = a_ovf; assign o_ov[1] = b_ovf;
    assign o_to[0] = a_to;  assign o_to[1] = b_to;
    assign o_h[0]  = a_h;   assign o_h[1]  = b_h;
    assign o_fd[0] = a_fd;  assign o_fd[1] = b_fd;
    assign o_fg[0] = a_fg;  assign o_fg[1] = b_fg;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: two queues per checker, commits filtered at x0,
    // one in-order compare per cycle, halting on the listed error events.
    ent_t mqd [2][$];
    ent_t mqg [2][$];
    int   mmc [2];
    int   mmm [2];
    int   mfi [2];
    int   mtc [2];
    bit   mfv [2];
    bit   movf[2];
    bit   mto [2];
    bit   mh  [2];
    ent_t mfd [2];
    ent_t mfg [2];
    int   cmax[2] = '{65535, 15};
    bit   stopf[2] = '{1'b1, 1'b0};

    task automatic model_step();
        ent_t hd, hg;
        bit   hlt, one;
        for (int i = 0; i < 2; i++) begin
            if (RESET) begin
                mqd[i].delete(); mqg[i].delete();
                mmc[i] = 0; mmm[i] = 0; mfi[i] = 0; mtc[i] = 0;
                mfv[i] = 0; movf[i] = 0; mto[i] = 0; mh[i] = 0;
                mfd[i] = '0; mfg[i] = '0;
                continue;
            end
            if (mh[i]) continue;
            hlt = 0;
            if (mqd[i].size() > 0 && mqg[i].size() > 0) begin
                hd = mqd[i].pop_front();
                hg = mqg[i].pop_front();
                if (hd == hg) begin
                    if (mmc[i] < cmax[i]) mmc[i]++;
                end else begin
                    if (!mfv[i]) begin
                        mfv[i] = 1; mfi[i] = (mmc[i] + mmm[i]) & cmax[i];
                        mfd[i] = hd; mfg[i] = hg;
                    end
                    if (mmm[i] < cmax[i]) mmm[i]++;
                    if (stopf[i]) hlt = 1;
                end
            end
            if (bus.dut_we && bus.dut_reg != 0) begin
                if (mqd[i].size() == 8) begin movf[i] = 1; hlt = 1; end
                else mqd[i].push_back({bus.dut_reg, bus.dut_data});
            end
            if (bus.gold_we && bus.gold_reg != 0) begin
                if (mqg[i].size() == 8) begin movf[i] = 1; hlt = 1; end
                else mqg[i].push_back({bus.gold_reg, bus.gold_data});
            end
            one = (mqd[i].size() != 0) != (mqg[i].size() != 0);
            mtc[i] = one ? mtc[i] + 1 : 0;
            if (mtc[i] == 64) begin mto[i] = 1; hlt = 1; end
            if (hlt) mh[i] = 1;
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model u%0d match_count", i),    o_mc[i], mmc[i]);
            chk($sformatf("model u%0d mismatch_count", i), o_mm[i], mmm[i]);
            chk($sformatf("model u%0d first_valid", i),    o_fv[i], mfv[i]);
            chk($sformatf("model u%0d first_index", i),    o_fi[i], mfi[i]);
            chk($sformatf("model u%0d first_dut", i),      o_fd[i], mfd[i]);
            chk($sformatf("model u%0d first_gold", i),     o_fg[i], mfg[i]);
            chk($sformatf("model u%0d overflow", i),       o_ov[i], movf[i]);
            chk($sformatf("model u%0d timeout", i),        o_to[i], mto[i]);
            chk($sformatf("model u%0d halted", i),         o_h[i],  mh[i]);
        end
    endtask

    task automatic drv(input bit r, input bit dwe, input logic [4:0] dr, input logic [31:0] dd,
                       input bit gwe, input logic [4:0] gr, input logic [31:0] gd);
        RESET = r;
        bus.dut_we = dwe;  bus.dut_reg = dr;  bus.dut_data = dd;
        bus.gold_we = gwe; bus.gold_reg = gr; bus.gold_data = gd;
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        model_check();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    task automatic do_reset();
        drv(1, 0, 0, 0, 0, 0, 0);
        cycle();
    endtask

    typedef struct {
        bit r; bit dwe; logic [4:0] dr; logic [31:0] dd;
        bit gwe; logic [4:0] gr; logic [31:0] gd;
        int em; int emm; bit eh;
    } vec_t;
    vec_t tbl [12];

    ent_t pend[$];
    ent_t e;

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 2, 2, 1, 0, 0};
        tbl[4]  = '{0, 1, 2, 2, 0, 0, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
        tbl[6]  = '{0, 1, 0, 7, 1, 0, 7, 2, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
        tbl[8]  = '{0, 1, 3, 4, 1, 3, 3, 2, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 2, 1, 1};
        tbl[10] = '{0, 1, 4, 4, 1, 4, 4, 2, 1, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 2, 1, 1};

        drv(1, 0, 0, 0, 0, 0, 0);
        for (int v = 0; v < 12; v++) begin
            drv(tbl[v].r, tbl[v].dwe, tbl[v].dr, tbl[v].dd, tbl[v].gwe, tbl[v].gr, tbl[v].gd);
            cycle();
            chk($sformatf("vec%0d match_count", v),    a_mc, tbl[v].em);
            chk($sformatf("vec%0d mismatch_count", v), a_mm, tbl[v].emm);
            chk($sformatf("vec%0d halted", v),         a_h,  tbl[v].eh);
        end

        // Identical streams, DUT three cycles behind.
        do_reset();
        for (int t = 0; t < 14; t++) begin
            drv(0, (t >= 3 && t < 13), 5'(t - 2), 32'(t - 2), (t < 10), 5'(t + 1), 32'(t + 1));
            cycle();
        end
        idle(3);
        chk("skew match_count", a_mc, 10);
        chk("skew mismatch_count", a_mm, 0);
        chk("skew halted", a_h, 0);
        chk("skew timeout", a_to, 0);

        // Single mismatch on the fifth compare halts the stopping checker.
        do_reset();
        for (int t = 0; t < 8; t++) begin
            drv(0, 1, 5'(t + 1), (t == 4) ? 32'hDEAD : 32'(t + 1), 1, 5'(t + 1), 32'(t + 1));
            cycle();
        end
        idle(2);
        chk("stop match_count", a_mc, 4);
        chk("stop mismatch_count", a_mm, 1);
        chk("stop first_valid", a_fv, 1);
        chk("stop first_index", a_fi, 4);
        chk("stop first_dut", a_fd, {5'd5, 32'hDEAD});
        chk("stop first_gold", a_fg, {5'd5, 32'h5});
        chk("stop halted", a_h, 1);

        // Non-stopping checker: mismatches at compare indices 2 and 7.
        do_reset();
        for (int t = 0; t < 10; t++) begin
            drv(0, 1, 5'(t + 1), (t == 2 || t == 7) ? 32'(t + 1) ^ 32'h100 : 32'(t + 1),
                1, 5'(t + 1), 32'(t + 1));
            cycle();
        end
        idle(2);
        chk("cont mismatch_count", b_mm, 2);
        chk("cont match_count", b_mc, 8);
        chk("cont first_index", b_fi, 2);
        chk("cont halted", b_h, 0);

        // Overflow on the ninth golden push.
        do_reset();
        for (int t = 0; t < 9; t++) begin
            drv(0, 0, 0, 0, 1, 5'(t + 1), 32'(t));
            cycle();
            if (t == 7) begin
                chk("ovf before overflow", a_ovf, 0);
                chk("ovf before halted", a_h, 0);
            end
        end
        chk("ovf overflow", a_ovf, 1);
        chk("ovf halted", a_h, 1);

        // Commits to x0 never enter the FIFOs.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            drv(0, 1, 0, 32'(t), 1, 0, 32'(t + 9));
            cycle();
        end
        idle(2);
        chk("x0 match_count", a_mc, 0);
        chk("x0 mismatch_count", a_mm, 0);
        chk("x0 halted", a_h, 0);

        // Timeout: push edge counts as the first of 64 lone-FIFO edges.
        do_reset();
        drv(0, 0, 0, 0, 1, 1, 32'h77);
        cycle();
        idle(62);
        chk("tmo early timeout", a_to, 0);
        chk("tmo early halted", a_h, 0);
        idle(1);
        chk("tmo timeout", a_to, 1);
        chk("tmo halted", a_h, 1);

        // Counter saturation on the 4-bit instance.
        do_reset();
        for (int t = 0; t < 20; t++) begin
            drv(0, 1, 5'((t % 31) + 1), 32'(t), 1, 5'((t % 31) + 1), 32'(t));
            cycle();
        end
        idle(2);
        chk("sat match_count 4bit", b_mc, 15);
        chk("sat match_count 16bit", a_mc, 20);

        // Reset mid-run discards buffered entries.
        do_reset();
        drv(0, 1, 1, 1, 1, 1, 2);
        cycle();
        for (int t = 0; t < 3; t++) begin
            drv(0, 0, 0, 0, 1, 5'(t + 2), 32'(t + 2));
            cycle();
        end
        idle(1);
        chk("rst pre mismatch_count", b_mm, 1);
        do_reset();
        chk("rst match_count", b_mc, 0);
        chk("rst mismatch_count", b_mm, 0);
        chk("rst first_valid", b_fv, 0);
        chk("rst first_index", b_fi, 0);
        chk("rst first_dut", b_fd, 0);
        chk("rst first_gold", b_fg, 0);
        chk("rst overflow", b_ovf, 0);
        chk("rst timeout", b_to, 0);
        chk("rst halted", b_h, 0);
        for (int t = 0; t < 2; t++) begin
            drv(0, 1, 5'(t + 5), 32'(t + 50), 1, 5'(t + 5), 32'(t + 50));
            cycle();
        end
        idle(2);
        chk("rst after match_count", b_mc, 2);
        chk("rst after mismatch_count", b_mm, 0);

        // Randomized streams: DUT replays the golden sequence with lag and rare corruption.
        do_reset();
        pend.delete();
        for (int c = 0; c < 1500; c++) begin
            bit r, gq, dq;
            logic [4:0]  gr;
            logic [31:0] gd;
            r  = ($urandom_range(0, 99) == 0);
            gq = ($urandom_range(0, 1) == 1) && ((c % 300) < 200);
            gr = 5'($urandom_range(0, 31));
            gd = $urandom;
            dq = (pend.size() > 0) && ($urandom_range(0, 9) < 4) && ((c % 300) < 200);
            e  = '0;
            if (dq) begin
                e = pend.pop_front();
                if ($urandom_range(0, 19) == 0) e[0] = ~e[0];
            end
            if (gq) pend.push_back({gr, gd});
            if (r) pend.delete();
            drv(r, dq, e[36:32], e[31:0], gq, gr, gd);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
